// File: rtl/peripheral_sync_hs_rx.sv
// peripheral_sync_hs_rx: receive side of a 4-phase req/ack handshake into the clk domain.
// Synchronizes req, captures the quasi-static data bus once per request, presents it on valid/ready.
`default_nettype none

module peripheral_sync_hs_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_async,
    input  logic [DATA_WIDTH-1:0] data_async,
    output logic                  ack_async,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  busy,
    output logic                  timeout_err,
    input  logic                  err_clr
);

    // Width stays at least 1 so a disabled timeout still elaborates cleanly.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   ack_nxt, valid_nxt, err_nxt;
    logic [DATA_WIDTH-1:0]  data_nxt;

    assign req_sync = sync_q[SYNC_STAGES-1];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ack_async   <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            ack_async   <= ack_nxt;
            valid_out   <= valid_nxt;
            data_out    <= data_nxt;
            cnt         <= cnt_nxt;
            timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack_nxt   = ack_async;
        valid_nxt = valid_out;
        data_nxt  = data_out;
        cnt_nxt   = cnt;
        // A timeout set below overrides this clear in the same cycle.
        err_nxt   = timeout_err & ~err_clr;

        case (state)
            IDLE: begin
                ack_nxt   = 1'b0;
                valid_nxt = 1'b0;
                if (req_sync) begin
                    data_nxt  = data_async;
                    valid_nxt = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (ready_in) begin
                    valid_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req_sync) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
                    err_nxt   = 1'b1;
                    ack_nxt   = 1'b0;
                    state_nxt = DRAIN;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DRAIN: begin
                ack_nxt   = 1'b0;
                valid_nxt = 1'b0;
                if (!req_sync) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_peripheral_sync_hs_rx.sv
// tb_peripheral_sync_hs_rx: directed test of peripheral_sync_hs_rx with SYNC_STAGES=2, TIMEOUT_CYCLES=16.
`default_nettype none

module tb_peripheral_sync_hs_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_async = 1'b0;
    logic [7:0] data_async = 8'h00;
    logic       ack_async;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in = 1'b0;
    logic       busy;
    logic       timeout_err;
    logic       err_clr = 1'b0;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int beats  = 0;
    logic [7:0] words[$];

    peripheral_sync_hs_rx #(
        .DATA_WIDTH    (8),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_async  (req_async),
        .data_async (data_async),
        .ack_async  (ack_async),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // Every accepted beat is logged so duplicates or reordering show up.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_in) begin
            beats++;
            words.push_back(data_out);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] w);
        data_async = w;
        req_async  = 1'b1;
        for (int i = 0; i < 20 && !ack_async; i++) tick();
        check("xfer_ack_rise", ack_async, 1);
        req_async = 1'b0;
        for (int i = 0; i < 20 && ack_async; i++) tick();
        check("xfer_ack_fall", ack_async, 0);
    endtask

    initial begin
        int base;

        // 1: reset values appear before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("rst_ack", ack_async, 0);
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err", timeout_err, 0);
        check("rst_data", data_out, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // 2: single transfer, latency
        data_async = 8'hA5;
        req_async  = 1'b1;
        ready_in   = 1'b1;
        tick();
        check("t2_valid_e0", valid_out, 0);
        tick();
        check("t2_valid_e1", valid_out, 0);
        tick();
        check("t2_valid_e2", valid_out, 1);
        check("t2_data_e2", data_out, 8'hA5);
        check("t2_ack_e2", ack_async, 0);
        tick();
        check("t2_ack_e3", ack_async, 1);
        check("t2_valid_e3", valid_out, 0);
        check("t2_busy_e3", busy, 1);
        req_async = 1'b0;
        tick();
        check("t2_ack_ef0", ack_async, 1);
        tick();
        check("t2_ack_ef1", ack_async, 1);
        tick();
        check("t2_ack_ef2", ack_async, 0);
        check("t2_busy_end", busy, 0);

        // 3: backpressure; data_async wiggles to show data_out is held
        ready_in   = 1'b0;
        data_async = 8'hA5;
        req_async  = 1'b1;
        tick(3);
        check("t3_valid", valid_out, 1);
        data_async = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid", valid_out, 1);
            check("t3_hold_data", data_out, 8'hA5);
            check("t3_hold_ack", ack_async, 0);
        end
        ready_in = 1'b1;
        tick();
        check("t3_ack_rise", ack_async, 1);
        check("t3_valid_drop", valid_out, 0);
        req_async = 1'b0;
        tick(3);
        check("t3_ack_fall", ack_async, 0);
        check("t3_busy", busy, 0);

        // 4: back-to-back words
        base = beats;
        words.delete();
        xfer(8'h3C);
        xfer(8'hC3);
        tick(6);
        check("t4_beats", beats - base, 2);
        check("t4_word0", (words.size() > 0) ? words[0] : 8'hxx, 8'h3C);
        check("t4_word1", (words.size() > 1) ? words[1] : 8'hxx, 8'hC3);

        // 5: timeout after 16 ACK cycles
        data_async = 8'h5A;
        req_async  = 1'b1;
        tick(3);
        check("t5_valid", valid_out, 1);
        tick();
        check("t5_ack", ack_async, 1);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t5_ack_hold", ack_async, 1);
            check("t5_err_low", timeout_err, 0);
        end
        tick();
        check("t5_ack_timeout", ack_async, 0);
        check("t5_err_set", timeout_err, 1);
        check("t5_busy_drain", busy, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_drain_valid", valid_out, 0);
            check("t5_err_sticky", timeout_err, 1);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_err_clr", timeout_err, 0);
        req_async = 1'b0;
        tick(3);
        check("t5_idle", busy, 0);
        data_async = 8'h66;
        req_async  = 1'b1;
        tick(3);
        check("t5_new_valid", valid_out, 1);
        check("t5_new_data", data_out, 8'h66);
        tick();
        check("t5_new_ack", ack_async, 1);
        req_async = 1'b0;
        tick(3);
        check("t5_new_ack_fall", ack_async, 0);

        // 6: reset while in ACK; held req becomes a new request
        data_async = 8'h99;
        req_async  = 1'b1;
        tick(4);
        check("t6_ack_pre", ack_async, 1);
        rst_n = 1'b0;
        #2;
        check("t6_rst_ack", ack_async, 0);
        check("t6_rst_valid", valid_out, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_data", data_out, 0);
        #2 rst_n = 1'b1;
        tick(2);
        check("t6_valid_e1", valid_out, 0);
        tick();
        check("t6_recapture_valid", valid_out, 1);
        check("t6_recapture_data", data_out, 8'h99);
        tick();
        check("t6_ack", ack_async, 1);
        req_async = 1'b0;
        tick(3);
        check("t6_ack_fall", ack_async, 0);
        check("t6_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
